// File: rtl/cpu_types_pkg.sv
// Shared core types: pipeline latch controller state encoding and flush depth.
package cpu_types_pkg;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      MEMWAIT = 2'd1,
      HALTED  = 2'd2
   } plctrl_state_t;

   // Latches squashed by a redirect: fd, dx, xm.
   localparam int PLCTRL_FLUSH_DEPTH = 3;

endpackage

// File: rtl/pipeline_latch_ctrl_if.sv
// Bundle of pipeline_latch_ctrl signals (everything except CLK/RST).
// Counter signals exist only when PIPE_PERF_EN is defined.
interface pipeline_latch_ctrl_if #(parameter int CNT_W = 32);

   logic freeze, threeInstrFlush, ihit, dhit, dmemREN, dmemWEN, halt_in;
   logic pc_en, fd_en, dx_en, xm_en, mw_en;
   logic fd_flush, dx_flush, xm_flush, mw_flush;
   logic halt, pend_flush;
`ifdef PIPE_PERF_EN
   logic [CNT_W-1:0] stall_cycles, flush_count, freeze_count;
`endif

   modport plc (
      input  freeze, threeInstrFlush, ihit, dhit, dmemREN, dmemWEN, halt_in,
      output pc_en, fd_en, dx_en, xm_en, mw_en,
      output fd_flush, dx_flush, xm_flush, mw_flush, halt, pend_flush
`ifdef PIPE_PERF_EN
      , output stall_cycles, flush_count, freeze_count
`endif
   );

   modport tb (
      output freeze, threeInstrFlush, ihit, dhit, dmemREN, dmemWEN, halt_in,
      input  pc_en, fd_en, dx_en, xm_en, mw_en,
      input  fd_flush, dx_flush, xm_flush, mw_flush, halt, pend_flush
`ifdef PIPE_PERF_EN
      , input stall_cycles, flush_count, freeze_count
`endif
   );

endinterface

// File: rtl/plc_sat_counter.sv
// CNT_W-wide event counter that sticks at all-ones; synchronous active-high reset.
module plc_sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             inc_i,
   output logic [CNT_W-1:0] count_o
);

   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (inc_i && (count_q != {CNT_W{1'b1}}))
         count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   always_ff @(posedge CLK) begin
      if (RST) count_q <= '0;
      else     count_q <= count_d;
   end

   assign count_o = count_q;

endmodule

// File: rtl/pipeline_latch_ctrl.sv
// Pipeline latch enable/flush controller; holds across D-cache misses and defers redirects.
// Optional performance counters enabled by defining PIPE_PERF_EN.
//
// state   | meaning
// RUN     | pipeline advancing normally (subject to hazards)
// MEMWAIT | stalled on an outstanding data-cache access
// HALTED  | halt retired; everything frozen until RST
module pipeline_latch_ctrl
   import cpu_types_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic CLK,
   input  logic RST,
   input  logic freeze,
   input  logic threeInstrFlush,
   input  logic ihit,
   input  logic dhit,
   input  logic dmemREN,
   input  logic dmemWEN,
   input  logic halt_in,
   output logic pc_en,
   output logic fd_en,
   output logic dx_en,
   output logic xm_en,
   output logic mw_en,
   output logic fd_flush,
   output logic dx_flush,
   output logic xm_flush,
   output logic mw_flush,
   output logic halt,
   output logic pend_flush
`ifdef PIPE_PERF_EN
   ,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count,
   output logic [CNT_W-1:0] freeze_count
`endif
);

   plctrl_state_t state_q, state_d;
   logic pend_flush_q, pend_flush_d;
   logic halt_q, halt_d;
   logic dbusy, flush_req, flush_act, freeze_act;
   logic [PLCTRL_FLUSH_DEPTH-1:0] flush_v;

   assign dbusy     = (dmemREN | dmemWEN) & ~dhit;
   assign flush_req = threeInstrFlush | pend_flush_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= RUN;
         pend_flush_q <= 1'b0;
         halt_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         pend_flush_q <= pend_flush_d;
         halt_q       <= halt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      pend_flush_d = pend_flush_q;
      if (state_q != HALTED) begin
         if (dbusy) begin
            state_d = MEMWAIT;
            if (threeInstrFlush) pend_flush_d = 1'b1;
         end else begin
            state_d = RUN;
            if (flush_req) pend_flush_d = 1'b0;
            if (halt_in && mw_en) state_d = HALTED;
         end
      end
      halt_d = (state_d == HALTED);
   end

   // Priority: dbusy > flush_req > freeze > ~ihit > advance.
   always_comb begin
      pc_en      = 1'b0;
      fd_en      = 1'b0;
      dx_en      = 1'b0;
      xm_en      = 1'b0;
      mw_en      = 1'b0;
      flush_v    = '0;
      mw_flush   = 1'b0;
      flush_act  = 1'b0;
      freeze_act = 1'b0;
      if (!RST && (state_q != HALTED) && !dbusy) begin
         dx_en = 1'b1;
         xm_en = 1'b1;
         mw_en = 1'b1;
         if (flush_req) begin
            pc_en     = 1'b1;
            fd_en     = 1'b1;
            flush_v   = '1;
            flush_act = 1'b1;
         end else if (freeze) begin
            flush_v    = 3'b010;
            freeze_act = 1'b1;
         end else if (!ihit) begin
            fd_en   = 1'b1;
            flush_v = 3'b100;
         end else begin
            pc_en = 1'b1;
            fd_en = 1'b1;
         end
      end
   end

   assign fd_flush   = flush_v[2];
   assign dx_flush   = flush_v[1];
   assign xm_flush   = flush_v[0];
   assign halt       = halt_q;
   assign pend_flush = pend_flush_q;

`ifdef PIPE_PERF_EN
   logic stall_inc;
   assign stall_inc = !RST && (state_q != HALTED) && !pc_en;

   plc_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .CLK(CLK), .RST(RST), .inc_i(stall_inc), .count_o(stall_cycles)
   );
   plc_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .CLK(CLK), .RST(RST), .inc_i(flush_act), .count_o(flush_count)
   );
   plc_sat_counter #(.CNT_W(CNT_W)) u_freeze_cnt (
      .CLK(CLK), .RST(RST), .inc_i(freeze_act), .count_o(freeze_count)
   );
`else
   logic unused_perf;
   assign unused_perf = flush_act ^ freeze_act;
   if (CNT_W < 1) begin : g_cnt_w_invalid
   end
`endif

endmodule
